// File: rtl/crc_serial_rx.sv
// Serial receiver for 8-data + 4-CRC frames. Checks the CRC bit-serially and
// presents each frame on a valid/ready output register, with a saturating error count.
module crc_serial_rx #(
  parameter int unsigned        DATA_W    = 8,
  parameter int unsigned        CRC_W     = 4,
  parameter logic [CRC_W-1:0]   POLY      = CRC_W'(4'b0101),
  parameter int unsigned        ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 sin,
  input  logic                 sin_valid,
  input  logic                 sof,
  input  logic                 out_ready,
  output logic                 out_valid,
  output logic [DATA_W-1:0]    data_out,
  output logic [CRC_W-1:0]     crc_rx,
  output logic                 crc_ok,
  output logic                 busy,
  output logic                 overrun,
  output logic [ERR_CNT_W-1:0] err_count
);

  localparam int unsigned FRAME_W = DATA_W + CRC_W;
  localparam int unsigned CNT_W   = $clog2(FRAME_W + 1);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_CRC} state_e;

  state_e               state_q, state_d;
  logic [DATA_W-1:0]    data_sr_q, data_sr_d;
  logic [CRC_W-2:0]     crc_sr_q, crc_sr_d;
  logic [CRC_W-1:0]     lfsr_q, lfsr_d;
  logic [CRC_W-1:0]     crc_calc_q, crc_calc_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 out_valid_q, out_valid_d;
  logic [DATA_W-1:0]    data_out_q, data_out_d;
  logic [CRC_W-1:0]     crc_rx_q, crc_rx_d;
  logic                 crc_ok_q, crc_ok_d;
  logic                 busy_q, busy_d;
  logic                 overrun_q, overrun_d;
  logic [ERR_CNT_W-1:0] err_count_q, err_count_d;

  logic                 complete;
  logic [CRC_W-1:0]     crc_full;
  logic                 frame_ok;
  logic [CRC_W-1:0]     lfsr_next;

  // One MSB-first step of the CRC LFSR.
  function automatic logic [CRC_W-1:0] lfsr_step(input logic [CRC_W-1:0] c, input logic d);
    logic fb;
    fb = d ^ c[CRC_W-1];
    return {c[CRC_W-2:0], 1'b0} ^ (fb ? POLY : '0);
  endfunction

  always_comb begin
    state_d     = state_q;
    data_sr_d   = data_sr_q;
    crc_sr_d    = crc_sr_q;
    lfsr_d      = lfsr_q;
    crc_calc_d  = crc_calc_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    data_out_d  = data_out_q;
    crc_rx_d    = crc_rx_q;
    crc_ok_d    = crc_ok_q;
    overrun_d   = 1'b0;
    err_count_d = err_count_q;
    complete    = 1'b0;
    crc_full    = {crc_sr_q, sin};
    frame_ok    = (crc_full == crc_calc_q);
    lfsr_next   = lfsr_step(lfsr_q, sin);

    // A qualified sof always starts a fresh frame, aborting any frame in progress.
    if (sin_valid) begin
      if (sof) begin
        data_sr_d = {data_sr_q[DATA_W-2:0], sin};
        lfsr_d    = lfsr_step('0, sin);
        cnt_d     = CNT_W'(1);
        state_d   = S_DATA;
      end else begin
        case (state_q)
          S_DATA: begin
            data_sr_d = {data_sr_q[DATA_W-2:0], sin};
            lfsr_d    = lfsr_next;
            cnt_d     = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(DATA_W - 1)) begin
              crc_calc_d = lfsr_next;
              state_d    = S_CRC;
            end
          end
          S_CRC: begin
            crc_sr_d = {crc_sr_q[CRC_W-3:0], sin};
            cnt_d    = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(FRAME_W - 1)) begin
              complete = 1'b1;
              cnt_d    = '0;
              state_d  = S_IDLE;
            end
          end
          default: state_d = S_IDLE;
        endcase
      end
    end

    if (out_valid_q && out_ready) out_valid_d = 1'b0;

    // A completed frame loads only if the register is free or draining this cycle.
    if (complete) begin
      if (!out_valid_q || out_ready) begin
        out_valid_d = 1'b1;
        data_out_d  = data_sr_q;
        crc_rx_d    = crc_full;
        crc_ok_d    = frame_ok;
      end else begin
        overrun_d = 1'b1;
      end
      if (!frame_ok && (err_count_q != '1)) err_count_d = err_count_q + ERR_CNT_W'(1);
    end

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      data_sr_q   <= '0;
      crc_sr_q    <= '0;
      lfsr_q      <= '0;
      crc_calc_q  <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      data_out_q  <= '0;
      crc_rx_q    <= '0;
      crc_ok_q    <= 1'b0;
      busy_q      <= 1'b0;
      overrun_q   <= 1'b0;
      err_count_q <= '0;
    end else begin
      state_q     <= state_d;
      data_sr_q   <= data_sr_d;
      crc_sr_q    <= crc_sr_d;
      lfsr_q      <= lfsr_d;
      crc_calc_q  <= crc_calc_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      data_out_q  <= data_out_d;
      crc_rx_q    <= crc_rx_d;
      crc_ok_q    <= crc_ok_d;
      busy_q      <= busy_d;
      overrun_q   <= overrun_d;
      err_count_q <= err_count_d;
    end
  end

  assign out_valid = out_valid_q;
  assign data_out  = data_out_q;
  assign crc_rx    = crc_rx_q;
  assign crc_ok    = crc_ok_q;
  assign busy      = busy_q;
  assign overrun   = overrun_q;
  assign err_count = err_count_q;

endmodule

// File: tb/tb_crc_serial_rx.sv
// Directed bench for crc_serial_rx: a frame table with hand-computed CRCs plus
// sequences for abort, overrun, error saturation and mid-frame reset.
module tb_crc_serial_rx;

  logic       clk = 1'b0;
  logic       rst;
  logic       sin;
  logic       sin_valid;
  logic       sof;
  logic       out_ready;
  logic       out_valid;
  logic [7:0] data_out;
  logic [3:0] crc_rx;
  logic       crc_ok;
  logic       busy;
  logic       overrun;
  logic [7:0] err_count;

  int n_cmp  = 0;
  int n_fail = 0;

  crc_serial_rx dut (
    .clk       (clk),
    .rst       (rst),
    .sin       (sin),
    .sin_valid (sin_valid),
    .sof       (sof),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .data_out  (data_out),
    .crc_rx    (crc_rx),
    .crc_ok    (crc_ok),
    .busy      (busy),
    .overrun   (overrun),
    .err_count (err_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic [3:0] crc;
    bit         gap;
    logic       ok;
    logic [7:0] err;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Bits are driven at a falling edge, sampled at the next rising edge.
  task automatic send_bit(input logic b, input logic s);
    sin       = b;
    sof       = s;
    sin_valid = 1'b1;
    @(negedge clk);
    sin_valid = 1'b0;
    sof       = 1'b0;
  endtask

  // gap=1 inserts two idle cycles between bits, with noise on sin/sof.
  task automatic send_frame(input logic [7:0] d, input logic [3:0] c, input bit gap, input bit chk_busy);
    logic [11:0] f;
    f = {d, c};
    for (int i = 11; i >= 0; i--) begin
      send_bit(f[i], i == 11);
      if (gap && i != 0) begin
        sin = ~f[i];
        sof = 1'b1;
        @(negedge clk);
        @(negedge clk);
        sof = 1'b0;
      end
      if (chk_busy && i != 0) chk("busy_in_frame", 32'(busy), 32'd1);
    end
  endtask

  initial begin
    vecs[0] = '{data: 8'hA5, crc: 4'h6, gap: 1'b0, ok: 1'b1, err: 8'd0};
    vecs[1] = '{data: 8'hA5, crc: 4'h7, gap: 1'b0, ok: 1'b0, err: 8'd1};
    vecs[2] = '{data: 8'h00, crc: 4'h0, gap: 1'b0, ok: 1'b1, err: 8'd1};
    vecs[3] = '{data: 8'hA5, crc: 4'h6, gap: 1'b1, ok: 1'b1, err: 8'd1};
    vecs[4] = '{data: 8'h01, crc: 4'h5, gap: 1'b0, ok: 1'b1, err: 8'd1};
    vecs[5] = '{data: 8'h80, crc: 4'hA, gap: 1'b0, ok: 1'b1, err: 8'd1};
    vecs[6] = '{data: 8'h80, crc: 4'hB, gap: 1'b0, ok: 1'b0, err: 8'd2};

    rst = 1'b0; sin = 1'b0; sin_valid = 1'b0; sof = 1'b0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy",      32'(busy),      32'd0);
    chk("rst_err",       32'(err_count), 32'd0);
    chk("rst_data",      32'(data_out),  32'd0);
    rst = 1'b1;
    @(negedge clk);

    // Bits without sof in IDLE are ignored.
    send_bit(1'b1, 1'b0);
    chk("idle_ignore_busy", 32'(busy), 32'd0);

    foreach (vecs[k]) begin
      send_frame(vecs[k].data, vecs[k].crc, vecs[k].gap, vecs[k].gap);
      chk("tbl_valid",  32'(out_valid), 32'd1);
      chk("tbl_data",   32'(data_out),  32'(vecs[k].data));
      chk("tbl_crc_rx", 32'(crc_rx),    32'(vecs[k].crc));
      chk("tbl_crc_ok", 32'(crc_ok),    32'(vecs[k].ok));
      chk("tbl_err",    32'(err_count), 32'(vecs[k].err));
      chk("tbl_busy",   32'(busy),      32'd0);
      @(negedge clk);
      chk("tbl_drained", 32'(out_valid), 32'd0);
    end

    // Abort: 5 data bits, then a new sof with a full good frame.
    send_bit(1'b1, 1'b1);
    for (int i = 0; i < 4; i++) send_bit(1'b1, 1'b0);
    chk("abort_busy", 32'(busy), 32'd1);
    send_frame(8'h00, 4'h0, 1'b0, 1'b0);
    chk("abort_valid", 32'(out_valid), 32'd1);
    chk("abort_data",  32'(data_out),  32'h00);
    chk("abort_ok",    32'(crc_ok),    32'd1);
    chk("abort_err",   32'(err_count), 32'd2);
    @(negedge clk);
    chk("abort_single", 32'(out_valid), 32'd0);

    // Overrun: consumer stalled across two frames.
    out_ready = 1'b0;
    send_frame(8'hA5, 4'h6, 1'b0, 1'b0);
    chk("ovr_first_valid", 32'(out_valid), 32'd1);
    chk("ovr_first_ovr",   32'(overrun),   32'd0);
    send_frame(8'h01, 4'h5, 1'b0, 1'b0);
    chk("ovr_pulse",  32'(overrun),   32'd1);
    chk("ovr_held_d", 32'(data_out),  32'hA5);
    chk("ovr_held_c", 32'(crc_rx),    32'h6);
    chk("ovr_valid",  32'(out_valid), 32'd1);
    @(negedge clk);
    chk("ovr_one_cycle", 32'(overrun), 32'd0);
    chk("ovr_still_a5",  32'(data_out), 32'hA5);
    out_ready = 1'b1;
    @(negedge clk);
    chk("ovr_drained", 32'(out_valid), 32'd0);

    // Saturation: 260 bad frames on top of the 2 already counted.
    for (int n = 0; n < 260; n++) send_frame(8'h80, 4'hB, 1'b0, 1'b0);
    chk("sat_err", 32'(err_count), 32'hFF);
    chk("sat_bad", 32'(crc_ok),    32'd0);

    // Reset in the middle of a frame.
    send_bit(1'b1, 1'b1);
    for (int i = 0; i < 4; i++) send_bit(1'b0, 1'b0);
    chk("mid_busy", 32'(busy), 32'd1);
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_busy",  32'(busy),      32'd0);
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_err",   32'(err_count), 32'd0);
    chk("mid_rst_data",  32'(data_out),  32'd0);
    chk("mid_rst_crc",   32'(crc_rx),    32'd0);
    chk("mid_rst_ovr",   32'(overrun),   32'd0);
    rst = 1'b1;
    @(negedge clk);
    send_bit(1'b0, 1'b0);
    chk("post_rst_idle", 32'(busy), 32'd0);
    send_frame(8'hA5, 4'h6, 1'b0, 1'b0);
    chk("post_rst_data", 32'(data_out),  32'hA5);
    chk("post_rst_ok",   32'(crc_ok),    32'd1);
    chk("post_rst_err",  32'(err_count), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/crc_serial_rx.md
Name: crc_serial_rx

Overview:
- Serial receive end for the 8-data + 4-CRC frame format built by the parallel transmitter.
- Accepts the frame one bit per qualified clock, MSB of data first, then CRC MSB first.
- Recomputes the CRC bit-serially, checks it, and presents the data byte, received CRC and status on a valid/ready output register.
- Keeps a saturating count of CRC failures for link monitoring.

Parameters:
DATA_W, 8, data bits per frame
CRC_W, 4, CRC bits per frame
POLY, 4'b0101, generator x^4+x^2+1, with the implicit x^4 term omitted
ERR_CNT_W, 8, width of the CRC error counter

Ports:
clk  in  1  clock; all logic on the rising edge
rst  in  1  synchronous reset, active-low (0 = reset)
sin  in  1  serial data bit
sin_valid  in  1  sin is sampled only when this is 1
sof  in  1  start of frame; qualified by sin_valid; marks the bit as data bit 7
out_ready  in  1  consumer accepts the output register
out_valid  out  1  output register holds an unconsumed frame
data_out  out  DATA_W  received data byte
crc_rx  out  CRC_W  CRC field as received
crc_ok  out  1  1 = recomputed CRC equals crc_rx; valid while out_valid=1
busy  out  1  a frame is in progress (state not IDLE)
overrun  out  1  one-cycle pulse when a completed frame is dropped
err_count  out  ERR_CNT_W  saturating count of frames with crc_ok=0

Behaviour:
- Reset (rst=0 at an edge):
  - all outputs 0; state IDLE; LFSR 0; bit counter 0.
  - Reset overrides everything, including in the middle of a frame; partial frames are discarded.
- CRC algorithm:
  - init 0, no reflection, no final XOR, MSB first.
  - Per bit d: fb = d ^ c[3]; c <= {c[2:0],1'b0} ^ (fb ? POLY : 0).
  - crc(8'hA5) = 4'h6; crc(8'h00) = 4'h0.
- State machine (states IDLE, DATA, CRC); transitions occur only on cycles with sin_valid=1:
  - IDLE: sof=1 → shift sin into the data shift register, LFSR steps from 0, bit counter=1, go to DATA. sof=0 → bits are ignored.
  - DATA: shift and step the LFSR. After the 8th data bit, latch the LFSR value as crc_calc and go to CRC.
  - CRC: shift into the crc shift register; the LFSR does not step. After the 4th CRC bit, complete the frame and go to IDLE.
  - sof=1 in DATA or CRC: abort the current frame silently (no output, no count). Treat that bit as data bit 7 of a new frame; the LFSR restarts from 0 using this bit.
  - sin_valid=0: hold all state. Gaps of any length are allowed between bits.
- Frame completion (the edge that samples the 12th bit):
  - The output register loads at that edge: out_valid=1 from the next cycle, so latency is 1 cycle after the last bit.
  - data_out = data bits; crc_rx = received CRC; crc_ok = (crc_rx == crc_calc).
  - If crc_ok=0, err_count increments at the same edge and saturates at all-ones.
- Output handshake:
  - Transfer occurs on any cycle with out_valid=1 and out_ready=1; out_valid then clears.
  - data_out, crc_rx and crc_ok hold stable while out_valid=1 and no transfer occurs.
  - Completion and transfer on the same edge: the new frame loads and out_valid stays 1.
  - Completion while out_valid=1 and out_ready=0: the new frame is dropped and the old frame is kept. overrun pulses high for 1 cycle. err_count still counts the dropped frame if its CRC fails.
- busy = 1 in DATA and CRC, 0 in IDLE.

Test Plan:
- Frame A5, CRC 6, sent contiguously with out_ready=1 → one cycle after the 12th bit: out_valid=1, data_out=8'hA5, crc_rx=4'h6, crc_ok=1, err_count=0.
- Frame A5 with CRC 7 → crc_ok=0, err_count=1. Frame 00 with CRC 0 → crc_ok=1, err_count stays 1.
- Frame A5/6 with sin_valid toggling 1-0-0-1 between bits → identical result to the contiguous case; busy=1 throughout the frame.
- 5 data bits sent, then a new sof followed by a full frame 00/0 → exactly one output, data 8'h00 with crc_ok=1; no error counted for the aborted frame.
- out_ready=0, two good frames back-to-back → first frame is held; overrun pulses once; the second frame is lost. Then out_ready=1 → out_valid drops the cycle after the transfer.
- 260 bad-CRC frames → err_count saturates at 8'hFF. rst=0 in the middle of a frame → all outputs 0 and state IDLE on the next cycle.
